shift_mult_seq: RTL and testbench

//  Parametrised bit-serial shift-add multiplier; successor of the 16-bit serial multiplier.

---
 rtl/shift_mult_seq.sv | 141 ++++++++++++++
 tb/tb_shift_mult_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_mult_seq.sv
// Bit-serial shift-add multiplier, signed/unsigned at runtime, full product plus fixed-point slice.
// Latency: done pulses WIDTH cycles after the accepting edge; one result per WIDTH+1 cycles.
// Backpressure: none; start is only sampled in IDLE/DONE and ignored while busy.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request, accepted in IDLE or DONE
//   signed_mode       1: a, b two's complement; 0: unsigned (latched with start)
//   a, b              multiplicand / multiplier (latched with start)
//   busy              high while the operation is running
//   done              one-cycle completion pulse; p/y/ovf valid from this cycle
//   p                 full 2*WIDTH-bit product
//   y                 p[FRAC+WIDTH-1:FRAC], saturated when SAT=1 and ovf=1
//   ovf               slice overflow flag of the current result
module shift_mult_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 16,
  parameter bit SAT   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic [WIDTH-1:0]   y,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic             mode_q;
  logic [WIDTH:0]   acc;   // running upper partial product
  logic [WIDTH-1:0] lo;    // unretired multiplier bits; product low half fills from the top

  logic               last;
  logic [WIDTH+1:0]   a_ext;
  logic [WIDTH+1:0]   acc_ext;
  logic [WIDTH+1:0]   addend;
  logic [WIDTH+1:0]   sum;
  logic [WIDTH:0]     acc_nxt;
  logic [WIDTH-1:0]   lo_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] hi_s;
  logic               sig_ok;
  logic               uns_ok;
  logic               ovf_nxt;
  logic [WIDTH-1:0]   slice;
  logic [WIDTH-1:0]   sat_val;
  logic [WIDTH-1:0]   y_nxt;

  // One shift-add step. The sum is kept two bits wider than the operand so an
  // unsigned carry or a signed excursion survives until the shift brings it
  // back into the WIDTH+1-bit accumulator.
  always_comb begin
    last    = (cnt == CNT_LAST);
    a_ext   = mode_q ? {{2{a_q[WIDTH-1]}}, a_q} : {2'b00, a_q};
    acc_ext = {mode_q & acc[WIDTH], acc};
    addend  = '0;
    if (lo[0]) begin
      // The signed MSB of the multiplier carries weight -2^(WIDTH-1).
      addend = (mode_q && last) ? -a_ext : a_ext;
    end
    sum     = acc_ext + addend;
    acc_nxt = sum[WIDTH+1:1];
    lo_nxt  = {sum[0], lo[WIDTH-1:1]};
    prod    = {acc_nxt[WIDTH-1:0], lo_nxt};
  end

  // Slice overflow: signed fits when every bit from the slice sign upward is
  // equal; unsigned fits when nothing above the slice is set. With FRAC=WIDTH
  // both tests degenerate to "always fits".
  always_comb begin
    hi_s    = $signed(prod) >>> (FRAC + WIDTH - 1);
    sig_ok  = (hi_s == '0) || (hi_s == '1);
    uns_ok  = ((prod >> (FRAC + WIDTH)) == '0);
    ovf_nxt = mode_q ? !sig_ok : !uns_ok;
    slice   = WIDTH'(prod >> FRAC);
    sat_val = '1;
    if (mode_q) begin
      sat_val = prod[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    y_nxt = (SAT && ovf_nxt) ? sat_val : slice;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      mode_q <= 1'b0;
      acc    <= '0;
      lo     <= '0;
      p      <= '0;
      y      <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q    <= a;
            lo     <= b;
            mode_q <= signed_mode;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            p     <= prod;
            y     <= y_nxt;
            ovf   <= ovf_nxt;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_shift_mult_seq.sv
// Bench for shift_mult_seq: eight instances with different WIDTH/FRAC/SAT share one stimulus bus.
// A cycle-level model predicts busy/done/p/y/ovf for every instance and is compared each cycle.
// Directed vectors add literal checks on latency, back-to-back operation and reset abort.
module tb_shift_mult_seq;

  localparam int N = 8;
  localparam int W_TAB [N] = '{16, 16, 16, 4, 4, 24, 24, 24};
  localparam int F_TAB [N] = '{16,  8,  8, 2, 0, 12, 24,  0};
  localparam int S_TAB [N] = '{ 1,  1,  0, 1, 0,  1,  0,  1};

  logic        clk;
  logic        rst;
  logic        start;
  logic        sm_in;
  logic [23:0] a_bus;
  logic [23:0] b_bus;

  logic [N-1:0][47:0] p_o;
  logic [N-1:0][23:0] y_o;
  logic [N-1:0]       busy_o;
  logic [N-1:0]       done_o;
  logic [N-1:0]       ovf_o;

  int checks   = 0;
  int failures = 0;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int W = W_TAB[gi];
    logic [2*W-1:0] pw;
    logic [W-1:0]   yw;
    logic           bw, dw, ow;
    shift_mult_seq #(.WIDTH(W), .FRAC(F_TAB[gi]), .SAT(S_TAB[gi] != 0)) u_dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(sm_in),
      .a(a_bus[W-1:0]), .b(b_bus[W-1:0]),
      .busy(bw), .done(dw), .p(pw), .y(yw), .ovf(ow)
    );
    assign p_o[gi]    = 48'(pw);
    assign y_o[gi]    = 24'(yw);
    assign busy_o[gi] = bw;
    assign done_o[gi] = dw;
    assign ovf_o[gi]  = ow;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: exact integer product in the selected mode, slice taken by
  // arithmetic division by 2^frac, overflow as a range test on that value.
  function automatic void ref_calc(input int w, input int frac, input int sat,
                                   input logic [23:0] av, input logic [23:0] bv, input bit sm,
                                   output logic [47:0] pv, output logic [23:0] yv, output bit ov);
    longint mask = (longint'(1) << w) - 1;
    longint x = longint'(av) & mask;
    longint z = longint'(bv) & mask;
    longint prod, sv, lo_lim, hi_lim;
    if (sm && (((x >> (w - 1)) & 1) != 0)) x = x - (longint'(1) << w);
    if (sm && (((z >> (w - 1)) & 1) != 0)) z = z - (longint'(1) << w);
    prod = x * z;
    pv = 48'(prod & ((longint'(1) << (2 * w)) - 1));
    sv = prod >>> frac;
    if (sm) begin
      lo_lim = -(longint'(1) << (w - 1));
      hi_lim = (longint'(1) << (w - 1)) - 1;
    end else begin
      lo_lim = 0;
      hi_lim = mask;
    end
    ov = (sv < lo_lim) || (sv > hi_lim);
    if (ov && sat != 0)
      yv = sm ? (prod < 0 ? 24'(longint'(1) << (w - 1)) : 24'(hi_lim)) : 24'(mask);
    else
      yv = 24'(sv & mask);
  endfunction

  // Cycle-level model: an accepted request at edge e completes at edge e+W;
  // a new request is taken at any edge after the previous completion edge.
  int          edge_no = 0;
  int          end_edge [N];
  logic [23:0] ma [N];
  logic [23:0] mb [N];
  bit          msm [N];
  logic [47:0] ep [N];
  logic [23:0] ey [N];
  bit          eo [N];
  bit          eb [N];
  bit          ed [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      end_edge[i] = -1;
      ep[i] = '0; ey[i] = '0; eo[i] = 0; eb[i] = 0; ed[i] = 0;
      ma[i] = '0; mb[i] = '0; msm[i] = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        edge_no++;
        for (int i = 0; i < N; i++) begin
          int old_end;
          old_end = end_edge[i];
          ed[i] = (edge_no == old_end);
          if (ed[i]) ref_calc(W_TAB[i], F_TAB[i], S_TAB[i], ma[i], mb[i], msm[i], ep[i], ey[i], eo[i]);
          if (edge_no > old_end && start) begin
            ma[i] = a_bus; mb[i] = b_bus; msm[i] = sm_in;
            end_edge[i] = edge_no + W_TAB[i];
          end
          eb[i] = (edge_no < end_edge[i]);
        end
      end
    end
  end

  bit run_chk = 1'b1;
  initial begin
    forever begin
      @(negedge clk);
      if (run_chk) begin
        for (int i = 0; i < N; i++) begin
          chk($sformatf("u%0d.busy", i), 48'(busy_o[i]), 48'(eb[i]));
          chk($sformatf("u%0d.done", i), 48'(done_o[i]), 48'(ed[i]));
          chk($sformatf("u%0d.p", i),    p_o[i],         ep[i]);
          chk($sformatf("u%0d.y", i),    48'(y_o[i]),    48'(ey[i]));
          chk($sformatf("u%0d.ovf", i),  48'(ovf_o[i]),  48'(eo[i]));
        end
      end
    end
  end

  // One request, then 30 cycles so the widest instance also completes.
  // lat* = cycles from the accepting edge to the done cycle, -1 if never seen.
  task automatic go(input logic [23:0] av, input logic [23:0] bv, input bit sm,
                    output int lat0, output int lat3, output int lat5);
    @(posedge clk); #1;
    a_bus = av; b_bus = bv; sm_in = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat0 = -1; lat3 = -1; lat5 = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done_o[0] && lat0 < 0) lat0 = k - 1;
      if (done_o[3] && lat3 < 0) lat3 = k - 1;
      if (done_o[5] && lat5 < 0) lat5 = k - 1;
    end
  endtask

  initial begin
    int l0, l3, l5, d1, d2;
    logic [47:0] pv, pp1, pp2;
    logic [23:0] yv;
    bit ov;
    logic [23:0] corner_a [6] = '{24'h000000, 24'hFFFFFF, 24'h800000, 24'h7FFFFF, 24'h00FFFF, 24'h008000};
    logic [23:0] corner_b [6] = '{24'h123456, 24'h000001, 24'h800000, 24'h800000, 24'h00FFFF, 24'h008000};

    rst = 1'b1; start = 1'b0; sm_in = 1'b0; a_bus = '0; b_bus = '0;

    // Pin the reference model with hand-computed values.
    ref_calc(16, 16, 1, 24'hFFFF, 24'hFFFF, 1'b0, pv, yv, ov);
    chk("model_u_ffff_p", pv, 48'hFFFE0001);
    chk("model_u_ffff_y", 48'(yv), 48'hFFFE);
    ref_calc(16, 16, 1, 24'h8000, 24'h7FFF, 1'b1, pv, yv, ov);
    chk("model_s_min_p", pv, 48'hC0008000);
    ref_calc(16, 8, 1, 24'h8100, 24'h0200, 1'b1, pv, yv, ov);
    chk("model_sat_neg_y", 48'(yv), 48'h8000);
    chk("model_sat_neg_ovf", 48'(ov), 48'h1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 48'(busy_o), 48'h0);
    chk("rst_done", 48'(done_o), 48'h0);
    chk("rst_p0", p_o[0], 48'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Unsigned full-scale, with latency of three widths.
    go(24'h00FFFF, 24'h00FFFF, 1'b0, l0, l3, l5);
    chk("lat_w16", 48'(l0), 48'd16);
    chk("lat_w4", 48'(l3), 48'd4);
    chk("lat_w24", 48'(l5), 48'd24);
    chk("u_ffff_p", p_o[0], 48'hFFFE0001);
    chk("u_ffff_y", 48'(y_o[0]), 48'hFFFE);
    chk("u_ffff_ovf", 48'(ovf_o[0]), 48'h0);

    // Signed products including min*min.
    go(24'h00FFFF, 24'h00FFFF, 1'b1, l0, l3, l5);
    chk("s_m1m1_p", p_o[0], 48'h00000001);
    go(24'h008000, 24'h008000, 1'b1, l0, l3, l5);
    chk("s_minmin_p", p_o[0], 48'h40000000);
    go(24'h008000, 24'h007FFF, 1'b1, l0, l3, l5);
    chk("s_minmax_p", p_o[0], 48'hC0008000);

    // Fixed-point slice FRAC=8 with and without saturation.
    go(24'h000180, 24'h000200, 1'b1, l0, l3, l5);
    chk("fx_y", 48'(y_o[1]), 48'h0300);
    chk("fx_ovf", 48'(ovf_o[1]), 48'h0);
    go(24'h007F00, 24'h000200, 1'b1, l0, l3, l5);
    chk("fx_satpos_y", 48'(y_o[1]), 48'h7FFF);
    chk("fx_satpos_ovf", 48'(ovf_o[1]), 48'h1);
    chk("fx_raw_y", 48'(y_o[2]), 48'hFE00);
    chk("fx_raw_ovf", 48'(ovf_o[2]), 48'h1);
    go(24'h008100, 24'h000200, 1'b1, l0, l3, l5);
    chk("fx_satneg_y", 48'(y_o[1]), 48'h8000);
    chk("fx_satneg_ovf", 48'(ovf_o[1]), 48'h1);

    // start held high: back-to-back, operands changed while busy.
    @(posedge clk); #1;
    a_bus = 24'd3; b_bus = 24'd5; sm_in = 1'b0; start = 1'b1;
    @(posedge clk);
    d1 = -1; d2 = -1; pp1 = '0; pp2 = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3) begin
        a_bus = 24'd7; b_bus = 24'd9;
      end
      if (done_o[0]) begin
        if (d1 < 0) begin
          d1 = k - 1; pp1 = p_o[0];
        end else if (d2 < 0) begin
          d2 = k - 1; pp2 = p_o[0];
        end
      end
    end
    start = 1'b0;
    chk("b2b_lat1", 48'(d1), 48'd16);
    chk("b2b_lat2", 48'(d2), 48'd33);
    chk("b2b_p1", pp1, 48'd15);
    chk("b2b_p2", pp2, 48'd63);
    repeat (40) @(negedge clk);

    // Reset while cnt=7 aborts the operation.
    @(posedge clk); #1;
    a_bus = 24'h001234; b_bus = 24'h005678; sm_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 48'(busy_o[0]), 48'h0);
    chk("abort_done", 48'(done_o[0]), 48'h0);
    chk("abort_p", p_o[0], 48'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    go(24'd3, 24'd4, 1'b0, l0, l3, l5);
    chk("after_rst_p", p_o[0], 48'd12);

    // Corner operands in both modes, then random regression.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 6; i++)
        go(corner_a[i], corner_b[i], m[0], l0, l3, l5);
    for (int n = 0; n < 40; n++)
      go(24'($urandom), 24'($urandom), n[0], l0, l3, l5);

    run_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
